// File: rtl/red_pitaya_lpf_cascade.sv
// ---------------------------------------------------------------------------
// red_pitaya_lpf_cascade
//
// Purpose:
//   A chain of NSTAGES first-order IIR sections. Each section can be set to
//   bypass, lowpass or highpass, and each has its own bandwidth shift. The
//   chain gives a steeper roll-off in front of the PID/IQ paths.
//   The shift/mode settings are shadow inputs. They take effect together,
//   in one clock, when load_i is pulsed. The highpass output saturates and
//   raises a sticky flag. A busy window covers the pipeline flush that
//   follows a reconfiguration.
//
// Ports:
//   clk_i      system clock
//   rstn_i     asynchronous active-low reset
//   shift_i    shadow shift per stage, stage k in [k*SHIFTBITS +: SHIFTBITS]
//   mode_i     shadow mode per stage, {highpass,on} in [2k+1:2k], on=0 bypass
//   load_i     one-cycle strobe that copies the shadow config into the active one
//   sat_clr_i  clears sat_o
//   signal_i   signed input sample, one per clock
//   signal_o   signed, registered output of the last stage
//   sat_o      sticky flag: a highpass stage clipped since the last clear
//   busy_o     high for 2*NSTAGES cycles after the latest load_i
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module red_pitaya_lpf_cascade #(
    parameter int NSTAGES    = 4,
    parameter int SIGNALBITS = 14,
    parameter int SHIFTBITS  = 5,
    parameter int MAXSHIFT   = 24
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [NSTAGES*SHIFTBITS-1:0]   shift_i,
    input  logic [2*NSTAGES-1:0]           mode_i,
    input  logic                           load_i,
    input  logic                           sat_clr_i,
    input  logic signed [SIGNALBITS-1:0]   signal_i,
    output logic signed [SIGNALBITS-1:0]   signal_o,
    output logic                           sat_o,
    output logic                           busy_o
);

    localparam int SB   = SIGNALBITS;
    localparam int DW   = SIGNALBITS + 1;
    localparam int ACCW = SIGNALBITS + MAXSHIFT;
    localparam int CNTW = $clog2(2*NSTAGES + 1);

    localparam logic [CNTW-1:0]      BUSYLOAD = CNTW'(2*NSTAGES);
    localparam logic [SHIFTBITS-1:0] MAXS     = SHIFTBITS'(MAXSHIFT);
    localparam logic [SHIFTBITS-1:0] MINS     = SHIFTBITS'(1);
    localparam logic [SB-1:0]        SMAX     = {1'b0, {(SB-1){1'b1}}};
    localparam logic [SB-1:0]        SMIN     = {1'b1, {(SB-1){1'b0}}};
    localparam logic [ACCW-1:0]      AMAX     = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic [ACCW-1:0]      AMIN     = {1'b1, {(ACCW-1){1'b0}}};

    // Active configuration, the sticky saturation flag and the busy counter
    logic [NSTAGES*SHIFTBITS-1:0] r_shift;
    logic [2*NSTAGES-1:0]         r_mode;
    logic                         r_sat;
    logic [CNTW-1:0]              r_busyCnt;

    // Per-stage outputs and highpass clip indications, gathered from the generate loop
    logic [NSTAGES-1:0][SB-1:0]   w_stageOut;
    logic [NSTAGES-1:0]           w_clipHp;

    // The active config changes only on a load strobe. Filter state is
    // left alone, so switching modes is bumpless.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_shift <= '0;
            r_mode  <= '0;
        end else if (load_i) begin
            r_shift <= shift_i;
            r_mode  <= mode_i;
        end
    end

    // Each load restarts the flush window, even if one is already running
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_busyCnt <= '0;
        end else if (load_i) begin
            r_busyCnt <= BUSYLOAD;
        end else if (r_busyCnt != '0) begin
            r_busyCnt <= r_busyCnt - 1'b1;
        end
    end

    // A clip has priority over a clear, so a saturation in the same cycle as a clear is not lost
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sat <= 1'b0;
        end else if (|w_clipHp) begin
            r_sat <= 1'b1;
        end else if (sat_clr_i) begin
            r_sat <= 1'b0;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NSTAGES; k++) begin : gen_stage
            logic [SB-1:0]        w_x;
            logic [SHIFTBITS-1:0] w_shRaw;
            logic [SHIFTBITS-1:0] w_sh;
            logic [SHIFTBITS-1:0] w_amt;
            logic [SB-1:0]        w_yo;
            logic [DW-1:0]        w_delta;
            logic                 w_clip;
            logic [SB-1:0]        w_sat;
            logic [ACCW-1:0]      w_deltaExt;
            logic [ACCW-1:0]      w_inc;
            logic [ACCW:0]        w_sum;
            logic [ACCW-1:0]      w_yNext;
            logic                 w_on;
            logic                 w_hp;

            logic [ACCW-1:0]      r_y;
            logic [DW-1:0]        r_delta;
            logic [SB-1:0]        r_o;

            if (k == 0) begin : gen_first
                assign w_x = signal_i;
            end else begin : gen_chain
                assign w_x = w_stageOut[k-1];
            end

            assign w_on    = r_mode[2*k];
            assign w_hp    = r_mode[2*k+1];
            assign w_shRaw = r_shift[k*SHIFTBITS +: SHIFTBITS];

            // A shift of 0 behaves like 1. Shifts above MAXSHIFT are pinned to MAXSHIFT.
            assign w_sh  = (w_shRaw < MINS) ? MINS : ((w_shRaw > MAXS) ? MAXS : w_shRaw);
            assign w_amt = MAXS - w_sh;

            // The accumulator's integer part is its top SB bits. Delta has one extra bit, so the full input swing fits.
            assign w_yo    = r_y[ACCW-1 -: SB];
            assign w_delta = {w_x[SB-1], w_x} - {w_yo[SB-1], w_yo};

            // A delta that does not fit in SB bits is clipped for the highpass output
            assign w_clip = (w_delta[DW-1] != w_delta[DW-2]);
            assign w_sat  = w_clip ? (w_delta[DW-1] ? SMIN : SMAX) : w_delta[SB-1:0];

            // Gain 2^-s: sign-extend the registered delta, then scale it into the fractional field.
            // The loop delay can overshoot, so the sum saturates instead of wrapping.
            assign w_deltaExt = {{(ACCW-DW){r_delta[DW-1]}}, r_delta};
            assign w_inc      = w_deltaExt << w_amt;
            assign w_sum      = {r_y[ACCW-1], r_y} + {w_inc[ACCW-1], w_inc};
            assign w_yNext    = (w_sum[ACCW] != w_sum[ACCW-1]) ? (w_sum[ACCW] ? AMIN : AMAX)
                                                                : w_sum[ACCW-1:0];

            // The filter state runs in every mode, so a mode switch does not cause a jump.
            // The highpass output uses the same difference that is written into the delta register.
            // That keeps the stage at one cycle of latency.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_y     <= '0;
                    r_delta <= '0;
                    r_o     <= '0;
                end else begin
                    r_y     <= w_yNext;
                    r_delta <= w_delta;
                    if (!w_on) begin
                        r_o <= w_x;
                    end else if (!w_hp) begin
                        r_o <= w_yo;
                    end else begin
                        r_o <= w_sat;
                    end
                end
            end

            assign w_stageOut[k] = r_o;
            assign w_clipHp[k]   = w_on & w_hp & w_clip;
        end
    endgenerate

    assign signal_o = w_stageOut[NSTAGES-1];
    assign sat_o    = r_sat;
    assign busy_o   = (r_busyCnt != '0);

endmodule

// File: tb/tb_red_pitaya_lpf_cascade.sv
// ---------------------------------------------------------------------------
// tb_red_pitaya_lpf_cascade
//
// Directed self-checking bench for red_pitaya_lpf_cascade with default
// parameters (4 stages, 14-bit samples). Inputs are driven on the falling
// clock edge and outputs are sampled there too, away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_red_pitaya_lpf_cascade;

    logic               clk = 1'b0;
    logic               rstn_i;
    logic [19:0]        shift_i;
    logic [7:0]         mode_i;
    logic               load_i;
    logic               sat_clr_i;
    logic signed [13:0] signal_i;
    logic signed [13:0] signal_o;
    logic               sat_o;
    logic               busy_o;

    int checks   = 0;
    int failures = 0;

    red_pitaya_lpf_cascade dut (
        .clk_i     (clk),
        .rstn_i    (rstn_i),
        .shift_i   (shift_i),
        .mode_i    (mode_i),
        .load_i    (load_i),
        .sat_clr_i (sat_clr_i),
        .signal_i  (signal_i),
        .signal_o  (signal_o),
        .sat_o     (sat_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    // Drive helpers: these only apply stimulus
    task automatic doReset();
        rstn_i    = 1'b0;
        load_i    = 1'b0;
        sat_clr_i = 1'b0;
        signal_i  = '0;
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic loadConfig(input logic [19:0] sh, input logic [7:0] md);
        shift_i = sh;
        mode_i  = md;
        load_i  = 1'b1;
        @(negedge clk);
        load_i  = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (signal_o !== 14'sd0) begin
            failures++;
            $display("[TB] FAIL reset_signal: got %0d expected 0", signal_o);
        end
        checks++;
        if (sat_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_sat: got %b expected 0", sat_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy_o);
        end
    endtask

    // Impulse through an all-bypass chain shows up exactly 4 cycles later
    task automatic test_latency(input string tag);
        logic signed [13:0] exp;
        signal_i = 14'sd1234;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp = (i == 4) ? 14'sd1234 : 14'sd0;
            checks++;
            if (signal_o !== exp) begin
                failures++;
                $display("[TB] FAIL %s_sample%0d: got %0d expected %0d", tag, i, signal_o, exp);
            end
            signal_i = '0;
        end
    endtask

    task automatic test_lowpass();
        int peak;
        doReset();
        loadConfig(20'd1, 8'b0000_0001);
        repeat (4) @(negedge clk);
        signal_i = 14'sd1000;
        peak = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (int'(signal_o) > peak) peak = int'(signal_o);
        end
        checks++;
        if (peak > 1250) begin
            failures++;
            $display("[TB] FAIL lowpass_peak: got %0d expected <= 1250", peak);
        end
        checks++;
        if (signal_o !== 14'sd1000) begin
            failures++;
            $display("[TB] FAIL lowpass_settle: got %0d expected 1000", signal_o);
        end
    endtask

    task automatic test_highpass();
        int firstIdx;
        int firstVal;
        int prev;
        int cur;
        int badSteps;
        doReset();
        loadConfig(20'd4, 8'b0000_0011);
        repeat (4) @(negedge clk);
        signal_i = 14'sd4000;
        firstIdx = -1;
        firstVal = 0;
        prev     = 0;
        badSteps = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            cur = int'(signal_o);
            if (firstIdx < 0) begin
                if (cur != 0) begin
                    firstIdx = i;
                    firstVal = cur;
                end
            end else if (cur > prev) begin
                badSteps++;
            end
            prev = cur;
        end
        checks++;
        if (firstIdx != 4) begin
            failures++;
            $display("[TB] FAIL highpass_first_index: got %0d expected 4", firstIdx);
        end
        checks++;
        if (firstVal != 4000) begin
            failures++;
            $display("[TB] FAIL highpass_first_value: got %0d expected 4000", firstVal);
        end
        checks++;
        if (badSteps != 0) begin
            failures++;
            $display("[TB] FAIL highpass_monotonic: got %0d rising steps expected 0", badSteps);
        end
        checks++;
        if (prev > 1 || prev < -1) begin
            failures++;
            $display("[TB] FAIL highpass_decay: got %0d expected |x|<=1", prev);
        end
    endtask

    task automatic test_saturation();
        doReset();
        loadConfig(20'd10, 8'b0000_0011);
        signal_i = -14'sd8192;
        repeat (300) @(negedge clk);
        checks++;
        if (sat_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_before_step: got %b expected 0", sat_o);
        end
        signal_i = 14'sd8191;
        repeat (4) @(negedge clk);
        checks++;
        if (signal_o !== 14'sd8191) begin
            failures++;
            $display("[TB] FAIL sat_clipped_value: got %0d expected 8191", signal_o);
        end
        checks++;
        if (sat_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_set: got %b expected 1", sat_o);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (sat_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_sticky: got %b expected 1", sat_o);
        end
        // Clear while the stage is still clipping: the clip takes priority
        sat_clr_i = 1'b1;
        @(negedge clk);
        sat_clr_i = 1'b0;
        checks++;
        if (sat_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_clip_wins: got %b expected 1", sat_o);
        end
        loadConfig(20'd0, 8'b0000_0000);
        checks++;
        if (sat_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_load_untouched: got %b expected 1", sat_o);
        end
        sat_clr_i = 1'b1;
        @(negedge clk);
        sat_clr_i = 1'b0;
        checks++;
        if (sat_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_cleared: got %b expected 0", sat_o);
        end
    endtask

    task automatic test_atomic_load();
        logic busySamples [1:20];
        int   highs;
        doReset();
        shift_i  = '0;
        mode_i   = '0;
        signal_i = 14'sd500;
        repeat (6) @(negedge clk);
        checks++;
        if (signal_o !== 14'sd500) begin
            failures++;
            $display("[TB] FAIL atomic_baseline: got %0d expected 500", signal_o);
        end
        shift_i = 20'hFFFFF;
        mode_i  = 8'hFF;
        repeat (6) @(negedge clk);
        checks++;
        if (signal_o !== 14'sd500) begin
            failures++;
            $display("[TB] FAIL atomic_no_load: got %0d expected 500", signal_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL atomic_no_busy: got %b expected 0", busy_o);
        end

        // Single load: busy for exactly 8 cycles
        shift_i = '0;
        mode_i  = '0;
        load_i  = 1'b1;
        highs   = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            load_i = 1'b0;
            busySamples[i] = busy_o;
            if (busy_o === 1'b1) highs++;
        end
        checks++;
        if (highs != 8) begin
            failures++;
            $display("[TB] FAIL busy_single_len: got %0d expected 8", highs);
        end
        checks++;
        if (busySamples[8] !== 1'b1 || busySamples[9] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_single_edge: got %b%b expected 10", busySamples[8], busySamples[9]);
        end

        // A second load at busy cycle 3 restarts the 8-cycle window
        load_i = 1'b1;
        highs  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            load_i = (i == 3);
            busySamples[i] = busy_o;
            if (busy_o === 1'b1) highs++;
        end
        checks++;
        if (highs != 11) begin
            failures++;
            $display("[TB] FAIL busy_restart_len: got %0d expected 11", highs);
        end
        checks++;
        if (busySamples[11] !== 1'b1 || busySamples[12] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_restart_edge: got %b%b expected 10", busySamples[11], busySamples[12]);
        end
    endtask

    task automatic test_async_reset();
        doReset();
        loadConfig(20'd10, 8'b0000_0011);
        signal_i = -14'sd8192;
        repeat (100) @(negedge clk);
        signal_i = 14'sd8191;
        repeat (6) @(negedge clk);
        load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        checks++;
        if (signal_o !== 14'sd8191 || sat_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL async_precondition: got %0d/%b/%b expected 8191/1/1", signal_o, sat_o, busy_o);
        end
        // Assert reset between clock edges and look before the next rising edge
        #2;
        rstn_i = 1'b0;
        #1;
        checks++;
        if (signal_o !== 14'sd0 || sat_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_clear: got %0d/%b/%b expected 0/0/0", signal_o, sat_o, busy_o);
        end
        @(negedge clk);
        signal_i = '0;
        rstn_i   = 1'b1;
        @(negedge clk);
        test_latency("async_after");
    endtask

    initial begin
        rstn_i    = 1'b0;
        shift_i   = '0;
        mode_i    = '0;
        load_i    = 1'b0;
        sat_clr_i = 1'b0;
        signal_i  = '0;

        test_reset();
        test_latency("latency");
        test_lowpass();
        test_highpass();
        test_saturation();
        test_atomic_load();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
